// File: rtl/modulo_contador_sync_param_updown.sv
// Parametrised modulo-MODULUS up/down counter with parallel load, count enable
// and wrap/saturate bound mode. Cascade stages by feeding carry_out into the next enable.
module modulo_contador_sync_param_updown #(
    parameter int WIDTH       = 7,
    parameter int MODULUS     = 100,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_down,
    input  logic             saturate,
    output logic [WIDTH-1:0] q,
    output logic             carry_out,
    output logic             at_bound
);

    // Bound taken in WIDTH bits so MODULUS == 2**WIDTH does not overflow.
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_bound_q, at_bound_d;
    logic             at_max, at_zero;

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        count_d = count_q;
        if (!clear) begin
            count_d = RESET_VAL;
        end else if (load) begin
            count_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (enable) begin
            if (up_down) begin
                if (at_max) count_d = saturate ? count_q : '0;
                else        count_d = count_q + 1'b1;
            end else begin
                if (at_zero) count_d = saturate ? count_q : MAX_VAL;
                else         count_d = count_q - 1'b1;
            end
        end
        at_bound_d = up_down ? (count_d == MAX_VAL) : (count_d == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        count_q    <= count_d;
        at_bound_q <= at_bound_d;
    end

    assign q         = count_q;
    assign at_bound  = at_bound_q;
    assign carry_out = clear & enable & ~load & (up_down ? at_max : at_zero);

endmodule

// File: tb/tb_modulo_contador_sync_param_updown.sv
// Self-checking bench: scoreboard against an integer reference model, directed cases,
// a two-stage full-range cascade and a long random run.
module tb_modulo_contador_sync_param_updown;

    localparam int MOD = 100;

    logic       clock = 1'b0;
    logic       clear, enable, load, up_down, saturate;
    logic [6:0] load_value;
    logic [6:0] q;
    logic       carry_out, at_bound;

    logic       c_clear, c_en;
    logic [3:0] q0, q1;
    logic       carry0, carry1, ab0, ab1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int q;
        int ab;
    } exp_t;
    exp_t sb[$];
    int   m_q = 0;

    always #5 clock = ~clock;

    modulo_contador_sync_param_updown #(.WIDTH(7), .MODULUS(100), .RESET_VALUE(0)) dut (
        .clock(clock), .clear(clear), .enable(enable), .load(load),
        .load_value(load_value), .up_down(up_down), .saturate(saturate),
        .q(q), .carry_out(carry_out), .at_bound(at_bound)
    );

    modulo_contador_sync_param_updown #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) stage0 (
        .clock(clock), .clear(c_clear), .enable(c_en), .load(1'b0),
        .load_value(4'd0), .up_down(1'b1), .saturate(1'b0),
        .q(q0), .carry_out(carry0), .at_bound(ab0)
    );

    modulo_contador_sync_param_updown #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) stage1 (
        .clock(clock), .clear(c_clear), .enable(carry0), .load(1'b0),
        .load_value(4'd0), .up_down(1'b1), .saturate(1'b0),
        .q(q1), .carry_out(carry1), .at_bound(ab1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus on the main counter; called at a falling edge, returns at the next one.
    task automatic step(input logic clr, input logic ld, input logic [6:0] lv,
                        input logic en, input logic ud, input logic sat);
        exp_t e;
        int   nq;
        int   exp_carry;
        clear = clr; load = ld; load_value = lv; enable = en; up_down = ud; saturate = sat;
        #1;
        exp_carry = (clr && en && !ld && (ud ? (m_q == MOD - 1) : (m_q == 0))) ? 1 : 0;
        check("carry", {31'd0, carry_out}, exp_carry);
        if (!clr)                      nq = 0;
        else if (ld)                   nq = (int'(lv) >= MOD) ? MOD - 1 : int'(lv);
        else if (!en)                  nq = m_q;
        else if (ud)                   nq = (sat && m_q == MOD - 1) ? m_q : (m_q + 1) % MOD;
        else                           nq = (sat && m_q == 0) ? m_q : (m_q + MOD - 1) % MOD;
        e.q  = nq;
        e.ab = (ud ? (nq == MOD - 1) : (nq == 0)) ? 1 : 0;
        sb.push_back(e);
        m_q = nq;
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check("q", {25'd0, q}, e.q);
        check("at_bound", {31'd0, at_bound}, e.ab);
        check("q_in_range", {31'd0, (q < 7'(MOD))}, 1);
        @(negedge clock);
    endtask

    initial begin
        clear = 1'b0; load = 1'b0; enable = 1'b0; up_down = 1'b0; saturate = 1'b0;
        load_value = '0; c_clear = 1'b0; c_en = 1'b0;
        @(negedge clock);

        // T1 reset overrides load and enable
        step(0, 1, 7'd55, 1, 1, 0);
        step(0, 1, 7'd55, 1, 1, 0);
        check("t1_q", {25'd0, q}, 0);
        check("t1_carry", {31'd0, carry_out}, 0);

        // T2 up wrap
        step(1, 1, 7'd98, 0, 1, 0);
        step(1, 0, 7'd0, 1, 1, 0);
        check("t2_q99", {25'd0, q}, 99);
        check("t2_carry99", {31'd0, carry_out}, 1);
        step(1, 0, 7'd0, 1, 1, 0);
        check("t2_q0", {25'd0, q}, 0);
        check("t2_carry0", {31'd0, carry_out}, 0);
        step(1, 0, 7'd0, 1, 1, 0);
        check("t2_q1", {25'd0, q}, 1);

        // T3 down saturate
        step(1, 1, 7'd1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 7'd0, 1, 0, 1);
            check("t3_q", {25'd0, q}, 0);
            check("t3_at_bound", {31'd0, at_bound}, 1);
            check("t3_carry", {31'd0, carry_out}, 1);
        end

        // at_bound follows a direction change while holding one edge later
        step(1, 0, 7'd0, 0, 1, 1);
        check("dir_change_ab", {31'd0, at_bound}, 0);

        // T4 clamped load and priority
        step(1, 1, 7'd127, 0, 1, 0);
        check("t4_clamp", {25'd0, q}, 99);
        step(1, 1, 7'd5, 1, 1, 0);
        check("t4_load_q", {25'd0, q}, 5);
        check("t4_load_carry", {31'd0, carry_out}, 0);
        step(0, 1, 7'd40, 1, 1, 0);
        check("t4_clear_q", {25'd0, q}, 0);

        // T5 full-range cascade, 16 x 16
        c_clear = 1'b0; c_en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        c_clear = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            check("t5_carry0", {31'd0, carry0}, (q0 == 4'd15) ? 1 : 0);
            check("t5_carry1", {31'd0, carry1}, (q0 == 4'd15 && q1 == 4'd15) ? 1 : 0);
            @(posedge clock);
            #1;
            check("t5_count", {24'd0, q1, q0}, (i + 1) % 256);
            check("t5_ab0", {31'd0, ab0}, (((i + 1) % 16) == 15) ? 1 : 0);
            check("t5_ab1", {31'd0, ab1}, ((((i + 1) % 256) / 16) == 15) ? 1 : 0);
            @(negedge clock);
        end
        c_en = 1'b0;
        check("t5_q1", {28'd0, q1}, 2);
        check("t5_q0", {28'd0, q0}, 12);

        // T6 random
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0),
                 7'($urandom_range(0, 127)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
